// File: rtl/sdram_pkg.sv
// sdram_pkg: definitions shared by the SDR SDRAM responder model and the
// controller that drives it.
//   sdram_cmd_t   : {ras,cas,we} command encodings (chip-select low)
//   ERR_*         : protocol violation codes reported on err_code
//   MODE_*        : bit positions of the burst-length / CAS-latency fields
//                   inside the LOAD MODE address word
//   A_PRE_ALL     : address bit that turns PRECHARGE into precharge-all
//   burst_state_t : state of the data burst currently being served
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } sdram_cmd_t;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_CLOSED_BANK = 3'd1;
  localparam logic [2:0] ERR_ACT_OPEN    = 3'd2;
  localparam logic [2:0] ERR_REF_OPEN    = 3'd3;
  localparam logic [2:0] ERR_MRS_OPEN    = 3'd4;
  localparam logic [2:0] ERR_BAD_MODE    = 3'd5;

  localparam int MODE_BL_LSB = 0;
  localparam int MODE_BL_MSB = 2;
  localparam int MODE_CL_LSB = 4;
  localparam int MODE_CL_MSB = 6;
  localparam int A_PRE_ALL   = 10;

  typedef enum logic [1:0] {
    BURST_IDLE,
    BURST_READ,
    BURST_WRITE
  } burst_state_t;

endpackage

// File: rtl/sdram_bank_tracker.sv
// sdram_bank_tracker: open flag and open row for each of the four banks.
//   clk, rst    : clock and synchronous active-low reset (closes all banks)
//   act_en      : ACTIVE this cycle; opens 'bank' with row 'row_in'
//   pre_en      : PRECHARGE this cycle; closes 'bank', or all when pre_all
//   bank        : bank addressed by the current command (also lookup index)
//   bank_open   : open flag of 'bank'
//   bank_row    : row last activated in 'bank'
//   any_open    : at least one bank is open
module sdram_bank_tracker (
  input  logic        clk,
  input  logic        rst,
  input  logic        act_en,
  input  logic        pre_en,
  input  logic        pre_all,
  input  logic [1:0]  bank,
  input  logic [11:0] row_in,
  output logic        bank_open,
  output logic [11:0] bank_row,
  output logic        any_open
);

  logic [3:0]  open_q;
  logic [11:0] row_q [4];

  // Open flags: ACTIVE opens one bank, PRECHARGE closes one bank or all.
  always_ff @(posedge clk) begin
    if (!rst) begin
      open_q <= '0;
    end else if (act_en) begin
      open_q[bank] <= 1'b1;
    end else if (pre_en) begin
      if (pre_all) open_q <= '0;
      else         open_q[bank] <= 1'b0;
    end
  end

  // Row registers only matter while the bank is open, so they need no reset.
  always_ff @(posedge clk) begin
    if (act_en) row_q[bank] <= row_in;
  end

  assign bank_open = open_q[bank];
  assign bank_row  = row_q[bank];
  assign any_open  = |open_q;

endmodule

// File: rtl/sdram_responder_model.sv
// sdram_responder_model: cycle-accurate SDR SDRAM device responder.
//   clk, rst        : system clock, synchronous active-low reset
//   sdram_clk       : SDRAM clock; its sampled rising edge marks a command edge
//   sdram_cs1/ras/cas/we, sdram_ba, sdram_a : command, bank and address pins
//   sdram_dq_in     : write data from the controller
//   sdram_dq_out    : read data, valid while sdram_dq_oe is high
//   protocol_err    : sticky violation flag; err_code holds the first code
// Parameters: MEM_AW (backing-array address bits), COL_BITS (column bits of
// sdram_a), DEFAULT_CL (CAS latency until the first LOAD MODE, 2 or 3).
module sdram_responder_model
  import sdram_pkg::*;
#(
  parameter int MEM_AW     = 14,
  parameter int COL_BITS   = 9,
  parameter int DEFAULT_CL = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_clk,
  input  logic        sdram_cs1,
  input  logic        sdram_ras,
  input  logic        sdram_cas,
  input  logic        sdram_we,
  input  logic [1:0]  sdram_ba,
  input  logic [11:0] sdram_a,
  input  logic [15:0] sdram_dq_in,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic        protocol_err,
  output logic [2:0]  err_code
);

  // Column of burst beat k: sequential order, wrapping inside the aligned block.
  function automatic logic [COL_BITS-1:0] beat_column(input logic [COL_BITS-1:0] start,
                                                      input logic [2:0] k,
                                                      input logic [2:0] mask);
    logic [COL_BITS-1:0] m;
    m = COL_BITS'(mask);
    return (start & ~m) | ((start + COL_BITS'(k)) & m);
  endfunction

  logic                clk_q, cmd_edge;
  sdram_cmd_t          cmd;
  logic                is_rw, bad_mode;
  logic                bank_open, any_open;
  logic [11:0]         bank_row;
  logic                cl3_q;
  logic [2:0]          bl_mask_q;

  burst_state_t        burst_state, burst_next;
  logic [1:0]          burst_bank_q, burst_bank_n;
  logic [11:0]         burst_row_q, burst_row_n;
  logic [COL_BITS-1:0] burst_start_q, burst_start_n;
  logic [2:0]          burst_k_q, burst_k_n, burst_mask_q, burst_mask_n;

  logic                beat_valid, beat_read, mem_we;
  logic [1:0]          beat_bank;
  logic [11:0]         beat_row;
  logic [COL_BITS-1:0] beat_col;
  logic [MEM_AW-1:0]   beat_addr;

  logic [1:0]          pipe_valid_q;
  logic [MEM_AW-1:0]   pipe_addr_q [2];
  logic                out_valid;
  logic [MEM_AW-1:0]   out_addr;

  logic                err_req;
  logic [2:0]          err_val;

  logic [15:0]         mem [2**MEM_AW];

  // Previous sample of sdram_clk, used to find its rising edge in the clk domain.
  always_ff @(posedge clk) begin
    clk_q <= sdram_clk;
  end

  assign cmd_edge = sdram_clk & ~clk_q;
  assign cmd      = sdram_cs1 ? CMD_NOP : sdram_cmd_t'({sdram_ras, sdram_cas, sdram_we});
  assign is_rw    = (cmd == CMD_RD) || (cmd == CMD_WR);
  assign bad_mode = (sdram_a[MODE_BL_MSB:MODE_BL_LSB] > 3'd3) ||
                    ((sdram_a[MODE_CL_MSB:MODE_CL_LSB] != 3'd2) &&
                     (sdram_a[MODE_CL_MSB:MODE_CL_LSB] != 3'd3));

  sdram_bank_tracker u_banks (
    .clk       (clk),
    .rst       (rst),
    .act_en    (cmd_edge && cmd == CMD_ACT),
    .pre_en    (cmd_edge && cmd == CMD_PRE),
    .pre_all   (sdram_a[A_PRE_ALL]),
    .bank      (sdram_ba),
    .row_in    (sdram_a),
    .bank_open (bank_open),
    .bank_row  (bank_row),
    .any_open  (any_open)
  );

  // Burst sequencing: decides which beat (if any) is issued on this command
  // edge. A new READ/WRITE, BURST TERMINATE or PRECHARGE of the burst's bank
  // ends the running burst; a new access that hits an open bank starts one.
  always_comb begin
    burst_next    = burst_state;
    burst_bank_n  = burst_bank_q;
    burst_row_n   = burst_row_q;
    burst_start_n = burst_start_q;
    burst_k_n     = burst_k_q;
    burst_mask_n  = burst_mask_q;
    beat_valid    = 1'b0;
    beat_read     = 1'b0;
    beat_bank     = burst_bank_q;
    beat_row      = burst_row_q;
    beat_col      = burst_start_q;
    if (cmd_edge) begin
      if (burst_state != BURST_IDLE) begin
        if (is_rw || cmd == CMD_BST ||
            (cmd == CMD_PRE && (sdram_a[A_PRE_ALL] || sdram_ba == burst_bank_q))) begin
          burst_next = BURST_IDLE;
        end else begin
          beat_valid = 1'b1;
          beat_read  = (burst_state == BURST_READ);
          beat_col   = beat_column(burst_start_q, burst_k_q, burst_mask_q);
          burst_k_n  = burst_k_q + 3'd1;
          if (burst_k_q == burst_mask_q) burst_next = BURST_IDLE;
        end
      end
      if (is_rw && bank_open) begin
        beat_valid    = 1'b1;
        beat_read     = (cmd == CMD_RD);
        beat_bank     = sdram_ba;
        beat_row      = bank_row;
        beat_col      = sdram_a[COL_BITS-1:0];
        burst_bank_n  = sdram_ba;
        burst_row_n   = bank_row;
        burst_start_n = sdram_a[COL_BITS-1:0];
        burst_mask_n  = bl_mask_q;
        burst_k_n     = 3'd1;
        if (bl_mask_q == 3'd0)  burst_next = BURST_IDLE;
        else if (cmd == CMD_RD) burst_next = BURST_READ;
        else                    burst_next = BURST_WRITE;
      end
    end
  end

  // Burst state register; reset cancels any burst in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      burst_state   <= BURST_IDLE;
      burst_bank_q  <= '0;
      burst_row_q   <= '0;
      burst_start_q <= '0;
      burst_k_q     <= '0;
      burst_mask_q  <= '0;
    end else begin
      burst_state   <= burst_next;
      burst_bank_q  <= burst_bank_n;
      burst_row_q   <= burst_row_n;
      burst_start_q <= burst_start_n;
      burst_k_q     <= burst_k_n;
      burst_mask_q  <= burst_mask_n;
    end
  end

  assign beat_addr = MEM_AW'({beat_bank, beat_row, beat_col});
  assign mem_we    = rst && beat_valid && !beat_read;

  // Violation detection; only the first one is latched below.
  always_comb begin
    err_req = 1'b0;
    err_val = ERR_NONE;
    if (cmd_edge) begin
      unique case (cmd)
        CMD_RD, CMD_WR: if (!bank_open) begin err_req = 1'b1; err_val = ERR_CLOSED_BANK; end
        CMD_ACT:        if (bank_open)  begin err_req = 1'b1; err_val = ERR_ACT_OPEN;    end
        CMD_REF:        if (any_open)   begin err_req = 1'b1; err_val = ERR_REF_OPEN;    end
        CMD_MRS: begin
          if (any_open) begin
            err_req = 1'b1;
            err_val = ERR_MRS_OPEN;
          end else if (bad_mode) begin
            err_req = 1'b1;
            err_val = ERR_BAD_MODE;
          end
        end
        default: ;
      endcase
    end
  end

  // The read pipeline output tap depends on CL: with CL=2 a beat leaves one
  // command edge after issue, with CL=3 two edges after issue.
  assign out_valid = cl3_q ? pipe_valid_q[1] : pipe_valid_q[0];
  assign out_addr  = cl3_q ? pipe_addr_q[1]  : pipe_addr_q[0];

  // Read pipeline, read-data register, mode register and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_valid_q   <= '0;
      pipe_addr_q[0] <= '0;
      pipe_addr_q[1] <= '0;
      sdram_dq_out   <= '0;
      sdram_dq_oe    <= 1'b0;
      cl3_q          <= (DEFAULT_CL == 3);
      bl_mask_q      <= '0;
      protocol_err   <= 1'b0;
      err_code       <= ERR_NONE;
    end else if (cmd_edge) begin
      pipe_valid_q   <= {pipe_valid_q[0], beat_valid && beat_read};
      pipe_addr_q[0] <= beat_addr;
      pipe_addr_q[1] <= pipe_addr_q[0];
      sdram_dq_oe    <= out_valid;
      sdram_dq_out   <= out_valid ? mem[out_addr] : 16'h0000;
      if (cmd == CMD_MRS) begin
        cl3_q <= (sdram_a[MODE_CL_MSB:MODE_CL_LSB] == 3'd3);
        unique case (sdram_a[MODE_BL_MSB:MODE_BL_LSB])
          3'd1:    bl_mask_q <= 3'd1;
          3'd2:    bl_mask_q <= 3'd3;
          3'd3:    bl_mask_q <= 3'd7;
          default: bl_mask_q <= 3'd0;
        endcase
      end
      if (err_req && !protocol_err) begin
        protocol_err <= 1'b1;
        err_code     <= err_val;
      end
    end
  end

  // Backing array; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[beat_addr] <= sdram_dq_in;
  end

endmodule

// File: tb/tb_sdram_responder_model.sv
// tb_sdram_responder_model: directed bench for sdram_responder_model. A
// behavioural model schedules read beats by command-edge number and keeps its
// own memory, banks, mode and error state; a negedge process compares every
// cycle, and literal checks pin key values from hand calculation.
module tb_sdram_responder_model;

  localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        sdram_clk;
  logic        sdram_cs1, sdram_ras, sdram_cas, sdram_we;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_a;
  logic [15:0] sdram_dq_in;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;
  logic        protocol_err;
  logic [2:0]  err_code;

  int total = 0;
  int bad   = 0;
  bit check_en = 0;

  sdram_responder_model dut (
    .clk          (clk),
    .rst          (rst),
    .sdram_clk    (sdram_clk),
    .sdram_cs1    (sdram_cs1),
    .sdram_ras    (sdram_ras),
    .sdram_cas    (sdram_cas),
    .sdram_we     (sdram_we),
    .sdram_ba     (sdram_ba),
    .sdram_a      (sdram_a),
    .sdram_dq_in  (sdram_dq_in),
    .sdram_dq_out (sdram_dq_out),
    .sdram_dq_oe  (sdram_dq_oe),
    .protocol_err (protocol_err),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  typedef struct {
    int e;
    int addr;
    bit rd;
    int bank;
  } beat_t;

  logic [15:0] mmem [0:16383];
  bit          sched_v [0:1023];
  int          sched_a [0:1023];
  beat_t       pend [$];
  bit          m_open [0:3];
  int          m_row  [0:3];
  int          m_cl, m_bl, edge_n;
  logic        m_oe, m_err;
  logic [15:0] m_dq;
  logic [2:0]  m_code;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic raiseErr(input logic [2:0] code);
    if (!m_err) begin
      m_err  = 1'b1;
      m_code = code;
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 1024; i++) sched_v[i] = 0;
    pend.delete();
    for (int b = 0; b < 4; b++) m_open[b] = 0;
    m_cl = 2; m_bl = 1;
    m_oe = 0; m_dq = 16'h0; m_err = 0; m_code = 3'd0;
  endtask

  // One command edge of the model: output first (older memory contents),
  // then commands, then the beats due on this edge.
  task automatic modelEdge(input logic [2:0] cmd, input logic [1:0] ba,
                           input logic [11:0] a, input logic [15:0] dq);
    int col0, base, col;
    bit any;
    beat_t bt;
    m_oe = sched_v[edge_n];
    m_dq = m_oe ? mmem[sched_a[edge_n]] : 16'h0;
    any  = m_open[0] | m_open[1] | m_open[2] | m_open[3];
    if (cmd == C_RD || cmd == C_WR || cmd == C_BST ||
        (cmd == C_PRE && (a[10] || (pend.size() > 0 && pend[0].bank == int'(ba)))))
      pend.delete();
    case (cmd)
      C_RD, C_WR: begin
        if (!m_open[ba]) raiseErr(3'd1);
        else begin
          col0 = int'(a) % 512;
          base = col0 - (col0 % m_bl);
          for (int k = 0; k < m_bl; k++) begin
            col     = base + ((col0 + k) % m_bl);
            bt.e    = edge_n + k;
            bt.addr = (int'(ba) * 2097152 + m_row[ba] * 512 + col) % 16384;
            bt.rd   = (cmd == C_RD);
            bt.bank = int'(ba);
            pend.push_back(bt);
          end
        end
      end
      C_ACT: begin
        if (m_open[ba]) raiseErr(3'd2);
        m_open[ba] = 1;
        m_row[ba]  = int'(a);
      end
      C_PRE: begin
        if (a[10]) for (int b = 0; b < 4; b++) m_open[b] = 0;
        else m_open[ba] = 0;
      end
      C_REF: if (any) raiseErr(3'd3);
      C_MRS: begin
        if (any) raiseErr(3'd4);
        case (a[2:0])
          3'd0: m_bl = 1;
          3'd1: m_bl = 2;
          3'd2: m_bl = 4;
          3'd3: m_bl = 8;
          default: begin m_bl = 1; raiseErr(3'd5); end
        endcase
        if (a[6:4] == 3'd3) m_cl = 3;
        else begin
          m_cl = 2;
          if (a[6:4] != 3'd2) raiseErr(3'd5);
        end
      end
      default: ;
    endcase
    while (pend.size() > 0 && pend[0].e == edge_n) begin
      bt = pend.pop_front();
      if (bt.rd) begin
        sched_v[edge_n + m_cl - 1] = 1;
        sched_a[edge_n + m_cl - 1] = bt.addr;
      end else begin
        mmem[bt.addr] = dq;
      end
    end
    edge_n++;
  endtask

  // Drives one command edge (two clk cycles) and steps the model.
  task automatic applyStimulus(input logic [2:0] cmd, input logic [1:0] ba,
                               input logic [11:0] a, input logic [15:0] dq);
    sdram_cs1 = 1'b0;
    {sdram_ras, sdram_cas, sdram_we} = cmd;
    sdram_ba = ba; sdram_a = a; sdram_dq_in = dq;
    sdram_clk = 1'b1;
    @(posedge clk); #1;
    modelEdge(cmd, ba, a, dq);
    sdram_clk = 1'b0;
    sdram_cs1 = 1'b1;
    {sdram_ras, sdram_cas, sdram_we} = C_NOP;
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    sdram_clk = 1'b0;
    sdram_cs1 = 1'b1;
    @(posedge clk); #1;
    modelReset();
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic nop(input logic [15:0] dq);
    applyStimulus(C_NOP, 2'd0, 12'h000, dq);
  endtask

  // Model comparison on every cycle once the bench is out of reset.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("dq_oe", {15'b0, sdram_dq_oe}, {15'b0, m_oe});
      if (m_oe) checkOutput("dq_out", sdram_dq_out, m_dq);
      checkOutput("protocol_err", {15'b0, protocol_err}, {15'b0, m_err});
      checkOutput("err_code", {13'b0, err_code}, {13'b0, m_code});
    end
  end

  initial begin
    logic [15:0] exp3 [0:5];
    exp3[0] = 16'h0A00; exp3[1] = 16'h0A01; exp3[2] = 16'h0B08;
    exp3[3] = 16'h0B09; exp3[4] = 16'h0B0A; exp3[5] = 16'h0B0B;
    edge_n = 0;
    rst = 1'b0; sdram_clk = 1'b0; sdram_cs1 = 1'b1;
    {sdram_ras, sdram_cas, sdram_we} = C_NOP;
    sdram_ba = 2'd0; sdram_a = 12'h000; sdram_dq_in = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    doReset();
    check_en = 1;
    checkOutput("reset_dq_out", sdram_dq_out, 16'h0000);
    checkOutput("reset_dq_oe", {15'b0, sdram_dq_oe}, 16'h0000);
    checkOutput("reset_err", {15'b0, protocol_err}, 16'h0000);
    checkOutput("reset_code", {13'b0, err_code}, 16'h0000);

    // CL2 BL1 write then read
    applyStimulus(C_MRS, 2'd0, 12'h020, 16'h0);
    applyStimulus(C_ACT, 2'd1, 12'h005, 16'h0);
    applyStimulus(C_WR,  2'd1, 12'h010, 16'hBEEF);
    applyStimulus(C_RD,  2'd1, 12'h010, 16'h0);
    nop(16'h0);
    checkOutput("t1_dq", sdram_dq_out, 16'hBEEF);
    checkOutput("t1_oe", {15'b0, sdram_dq_oe}, 16'h0001);
    checkOutput("t1_err", {15'b0, protocol_err}, 16'h0000);
    nop(16'h0);

    // CL3 BL8 wrapping burst
    applyStimulus(C_PRE, 2'd0, 12'h400, 16'h0);
    applyStimulus(C_MRS, 2'd0, 12'h033, 16'h0);
    applyStimulus(C_ACT, 2'd1, 12'h005, 16'h0);
    applyStimulus(C_WR,  2'd1, 12'h006, 16'h1100);
    for (int k = 1; k < 8; k++) nop(16'h1100 + 16'(k));
    nop(16'h0);
    applyStimulus(C_RD, 2'd1, 12'h006, 16'h0);
    nop(16'h0);
    checkOutput("t2_oe_early", {15'b0, sdram_dq_oe}, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      nop(16'h0);
      checkOutput("t2_beat", sdram_dq_out, 16'h1100 + 16'(k));
    end
    nop(16'h0);
    checkOutput("t2_oe_end", {15'b0, sdram_dq_oe}, 16'h0000);

    // CL2 BL4 read interrupted by a second read
    applyStimulus(C_PRE, 2'd0, 12'h400, 16'h0);
    applyStimulus(C_MRS, 2'd0, 12'h022, 16'h0);
    applyStimulus(C_ACT, 2'd1, 12'h005, 16'h0);
    applyStimulus(C_WR,  2'd1, 12'h000, 16'h0A00);
    for (int k = 1; k < 4; k++) nop(16'h0A00 + 16'(k));
    applyStimulus(C_WR,  2'd1, 12'h008, 16'h0B08);
    for (int k = 1; k < 4; k++) nop(16'h0B08 + 16'(k));
    applyStimulus(C_RD,  2'd1, 12'h000, 16'h0);
    nop(16'h0);
    checkOutput("t3_beat", sdram_dq_out, exp3[0]);
    applyStimulus(C_RD,  2'd1, 12'h008, 16'h0);
    checkOutput("t3_beat", sdram_dq_out, exp3[1]);
    for (int k = 2; k < 6; k++) begin
      nop(16'h0);
      checkOutput("t3_beat", sdram_dq_out, exp3[k]);
      checkOutput("t3_oe", {15'b0, sdram_dq_oe}, 16'h0001);
    end
    nop(16'h0);
    checkOutput("t3_oe_end", {15'b0, sdram_dq_oe}, 16'h0000);
    applyStimulus(C_BST, 2'd0, 12'h000, 16'h0);

    // Precharge-all then refresh is legal
    applyStimulus(C_PRE, 2'd0, 12'h400, 16'h0);
    applyStimulus(C_REF, 2'd0, 12'h000, 16'h0);
    checkOutput("t5_ref_ok", {15'b0, protocol_err}, 16'h0000);

    // Read to a closed bank, then refresh with a bank open
    applyStimulus(C_ACT, 2'd1, 12'h005, 16'h0);
    applyStimulus(C_RD,  2'd2, 12'h000, 16'h0);
    checkOutput("t4_code", {13'b0, err_code}, 16'h0001);
    nop(16'h0);
    nop(16'h0);
    checkOutput("t4_oe", {15'b0, sdram_dq_oe}, 16'h0000);
    applyStimulus(C_REF, 2'd0, 12'h000, 16'h0);
    checkOutput("t4_sticky", {13'b0, err_code}, 16'h0001);

    // Double ACTIVE on bank 0
    doReset();
    applyStimulus(C_ACT, 2'd0, 12'h003, 16'h0);
    applyStimulus(C_ACT, 2'd0, 12'h004, 16'h0);
    checkOutput("t5_code", {13'b0, err_code}, 16'h0002);

    // Reset during a BL8 read
    doReset();
    applyStimulus(C_MRS, 2'd0, 12'h033, 16'h0);
    applyStimulus(C_ACT, 2'd1, 12'h005, 16'h0);
    applyStimulus(C_RD,  2'd1, 12'h006, 16'h0);
    for (int k = 0; k < 4; k++) nop(16'h0);
    doReset();
    checkOutput("t6_oe", {15'b0, sdram_dq_oe}, 16'h0000);
    checkOutput("t6_dq", sdram_dq_out, 16'h0000);
    applyStimulus(C_RD,  2'd2, 12'h000, 16'h0);
    checkOutput("t6_code", {13'b0, err_code}, 16'h0001);
    applyStimulus(C_ACT, 2'd1, 12'h005, 16'h0);
    applyStimulus(C_RD,  2'd1, 12'h007, 16'h0);
    nop(16'h0);
    checkOutput("t6_dq_cl2", sdram_dq_out, 16'h1101);
    checkOutput("t6_oe_cl2", {15'b0, sdram_dq_oe}, 16'h0001);
    nop(16'h0);
    nop(16'h0);

    check_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_responder_model.md
Name: sdram_responder_model

Overview:
- Cycle-accurate SDR SDRAM device model: the responder on the command/data pins that the 32MB controller drives.
- Decodes RAS/CAS/WE/CS commands, tracks open rows per bank, and honours the programmed CAS latency and burst length.
- Stores data in an internal array and flags protocol violations.
- Used in the dev-cart benches to verify the controller, and synthesizable so it can stand in for the SDRAM on FPGA loopback builds.

Parameters:
- MEM_AW, 14, word-address bits of the backing array (depth 2^MEM_AW x 16).
- COL_BITS, 9, column bits taken from sdram_a[COL_BITS-1:0].
- DEFAULT_CL, 2, CAS latency used before the first LOAD MODE.

Ports:
- clk  in  1  system clock; same clock as the controller.
- rst  in  1  synchronous, active-low reset.
- sdram_clk  in  1  SDRAM clock from the controller; its rising edges define command edges.
- sdram_cs1  in  1  chip select, active low.
- sdram_ras  in  1  RAS, active low.
- sdram_cas  in  1  CAS, active low.
- sdram_we  in  1  WE, active low.
- sdram_ba  in  2  bank address.
- sdram_a  in  12  row/column/mode address.
- sdram_dq_in  in  16  write data from the controller.
- sdram_dq_out  out  16  read data to the controller.
- sdram_dq_oe  out  1  high while the model drives read data.
- protocol_err  out  1  sticky violation flag.
- err_code  out  3  code of the first violation.

Behaviour:
- Command edge:
  - A clk cycle where the sampled sdram_clk is 1 and the previous sample was 0.
  - All decode and data capture happens only in command-edge cycles. Other cycles hold state.
- Reset (rst=0 at posedge clk):
  - sdram_dq_out=0, sdram_dq_oe=0, protocol_err=0, err_code=0.
  - All banks closed. CL=DEFAULT_CL, BL=1. Any burst in flight is cancelled.
  - The array is not cleared.
- Command decode (cs1=0; {ras,cas,we}):
  - 111: NOP.
  - 011: ACTIVE. open[ba]<=1, row[ba]<=a.
  - 101: READ.
  - 100: WRITE.
  - 010: PRECHARGE. Closes bank ba, or all banks if a[10]=1.
  - 001: AUTO REFRESH.
  - 000: LOAD MODE.
  - 110: BURST TERMINATE.
  - cs1=1: treated as NOP.
- LOAD MODE:
  - BL from a[2:0]: 0->1, 1->2, 2->4, 3->8; other values -> BL=1 plus error 5.
  - CL from a[6:4]: 2 or 3; other values -> CL=2 plus error 5.
- Array address:
  - {ba, row[ba], col} truncated to the low MEM_AW bits.
  - Burst beat k uses col = (start & ~(BL-1)) | ((start+k) & (BL-1)), i.e. sequential order, wrapping inside the BL-aligned block.
- WRITE at edge n:
  - Beat 0 captured from sdram_dq_in at edge n; beat k at edge n+k, for k<BL.
- READ at edge n:
  - Beat k is registered onto sdram_dq_out with sdram_dq_oe=1 in the command-edge cycle of edge n+CL-1+k, so the controller samples it at edge n+CL+k.
  - dq_oe drops in the command-edge cycle after the last beat.
  - Read latency is implemented as a CL-deep pipeline of {valid, addr} advanced on command edges.
- Interruption:
  - A new READ or WRITE, or a BURST TERMINATE, ends the current burst.
  - Read beats already inside the CL pipeline still emit; no further beats are issued.
  - READ immediately following WRITE: the write burst stops at that edge.
- A PRECHARGE on the bank of an active burst stops the burst at that edge.
- Error codes (sticky; the first error latches err_code, later errors are ignored until reset):
  - 1: READ/WRITE to a closed bank. Access is dropped.
  - 2: ACTIVE to an already-open bank. Row is still updated.
  - 3: AUTO REFRESH while any bank is open.
  - 4: LOAD MODE while any bank is open. Mode is still applied.
  - 5: illegal mode field.
- Simultaneous events:
  - Read-pipeline output and a new command on the same edge: both are processed; output is from the earlier command.
  - A reset asserted mid-burst wins.
- Timing parameters (tRCD, tRP, tRFC) are not checked.

Decomposition:
- Shared package sdram_pkg:
  - Command encodings CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS, CMD_BST.
  - Error code constants.
  - Mode-field bit positions.
  - This package is also consumed by the controller.
- One sub-module, sdram_bank_tracker: per-bank open flag and row register, with ACTIVE/PRECHARGE/precharge-all inputs and row lookup by bank.

Test Plan:
- Reset, MRS a=0x020 (CL2, BL1), ACT ba=1 row=0x005, WR col=0x010 data=0xBEEF, RD col=0x010 -> dq_out=0xBEEF with dq_oe=1 at edge RD+2; err=0.
- MRS a=0x033 (CL3, BL8), ACT, WR burst col=0x006 with data 0..7, RD col=0x006 -> beats 0..7 returned from columns 6,7,0,1,2,3,4,5; first beat at edge RD+3.
- BL4 read at col=0, then a new READ at col=8 two edges later -> exactly 2 beats of the first burst, then 4 beats of the second; dq_oe continuous.
- RD to bank 2 with no ACTIVE -> protocol_err=1, err_code=1, dq_oe stays 0; a later REF with a bank open leaves err_code at 1.
- PRECHARGE with a[10]=1 then AUTO REFRESH -> no error; ACT twice on bank 0 -> err_code=2.
- rst pulled low during an active BL8 read -> the next clk gives dq_oe=0 and dq_out=0; after release, CL=DEFAULT_CL and a READ to a closed bank flags err_code 1.
